// File: rtl/mnet_stream_adapter.sv
// mnet_stream_adapter: deserialises a pixel stream into the network frame bus,
// waits a settle time, captures the class scores and serialises them out.
// Optional feature macro ARGMAX_EN adds class_idx/class_valid (argmax of captured scores).
module mnet_stream_adapter #(
  parameter int INPUT_SIZE      = 32,
  parameter int INPUT_CHANNELS  = 3,
  parameter int PX_SIZE         = 8,
  parameter int OUTPUT_CHANNELS = 10,
  parameter int SETTLE_CYCLES   = 4
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic                                                   s_valid,
  output logic                                                   s_ready,
  input  logic [PX_SIZE-1:0]                                     s_data,
  input  logic                                                   s_last,
  output logic [INPUT_SIZE*INPUT_SIZE*INPUT_CHANNELS*PX_SIZE-1:0] net_img,
  input  logic [OUTPUT_CHANNELS*PX_SIZE-1:0]                     net_scores,
  output logic                                                   m_valid,
  input  logic                                                   m_ready,
  output logic [PX_SIZE-1:0]                                     m_data,
  output logic                                                   m_last,
  output logic                                                   busy,
  output logic                                                   frame_err
`ifdef ARGMAX_EN
  ,
  output logic [$clog2(OUTPUT_CHANNELS)-1:0]                     class_idx,
  output logic                                                   class_valid
`endif
);
  localparam int N  = INPUT_SIZE * INPUT_SIZE * INPUT_CHANNELS;
  localparam int PW = $clog2(N + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int IW = $clog2(OUTPUT_CHANNELS);
  typedef enum logic [1:0] {LOAD, SETTLE, SEND} state_t;
  state_t                           r_state, w_next;
  logic [PW-1:0]                    r_pix;
  logic [SW-1:0]                    r_settle;
  logic [IW-1:0]                    r_idx;
  logic [OUTPUT_CHANNELS*PX_SIZE-1:0] r_score;
  logic [N*PX_SIZE-1:0]             r_img;
  logic                             r_s_ready;
  logic                             r_frame_err;
  logic                             w_accept;
  logic                             w_final;
  logic                             w_capture;
  logic                             w_send_hs;
  logic                             w_last_hs;
  assign w_accept  = (r_state == LOAD) && s_valid && r_s_ready;
  assign w_final   = r_pix == PW'(N - 1);
  assign w_capture = (r_state == SETTLE) && (r_settle == '0);
  assign w_send_hs = (r_state == SEND) && m_ready;
  assign w_last_hs = w_send_hs && (r_idx == IW'(OUTPUT_CHANNELS - 1));
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= LOAD;
    else r_state <= w_next;
  // next-state: load a full frame, settle, then send every score
  always_comb begin
    w_next = r_state;
    case (r_state)
      LOAD:    w_next = (w_accept && w_final) ? SETTLE : LOAD;
      SETTLE:  w_next = w_capture ? SEND : SETTLE;
      SEND:    w_next = w_last_hs ? LOAD : SEND;
      default: w_next = LOAD;
    endcase
  end
  // datapath: frame buffer, counters, score capture and registered handshakes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_img       <= '0;
      r_score     <= '0;
      r_pix       <= '0;
      r_settle    <= '0;
      r_idx       <= '0;
      r_s_ready   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_s_ready   <= (w_next == LOAD);
      r_frame_err <= w_accept && (w_final ? !s_last : s_last);
      if (w_accept) begin
        r_img[r_pix*PX_SIZE +: PX_SIZE] <= s_data;
        r_pix <= (w_final || s_last) ? '0 : r_pix + 1'b1;
      end
      if (w_accept && w_final) r_settle <= SW'(SETTLE_CYCLES - 1);
      else if (r_state == SETTLE && !w_capture) r_settle <= r_settle - 1'b1;
      if (w_capture) begin
        r_score <= net_scores;
        r_idx   <= '0;
      end else if (w_send_hs) r_idx <= w_last_hs ? '0 : r_idx + 1'b1;
    end
  assign s_ready   = r_s_ready;
  assign net_img   = r_img;
  assign m_valid   = r_state == SEND;
  assign m_data    = m_valid ? r_score[r_idx*PX_SIZE +: PX_SIZE] : '0;
  assign m_last    = m_valid && (r_idx == IW'(OUTPUT_CHANNELS - 1));
  assign busy      = r_state != LOAD;
  assign frame_err = r_frame_err;
`ifdef ARGMAX_EN
  logic [IW-1:0]             w_best_idx;
  logic [IW-1:0]             r_class_idx;
  logic signed [PX_SIZE-1:0] w_best;
  // highest signed score; strict compare keeps the lowest index on ties
  always_comb begin
    w_best     = net_scores[PX_SIZE-1:0];
    w_best_idx = '0;
    for (int c = 1; c < OUTPUT_CHANNELS; c++)
      if ($signed(net_scores[c*PX_SIZE +: PX_SIZE]) > w_best) begin
        w_best     = net_scores[c*PX_SIZE +: PX_SIZE];
        w_best_idx = IW'(c);
      end
  end
  // latch the winning class alongside the score capture
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_class_idx <= '0;
    else if (w_capture) r_class_idx <= w_best_idx;
  assign class_idx   = r_class_idx;
  assign class_valid = m_valid;
`endif
endmodule
